fp_spi_host: RTL
================

Name: fp_spi_host

Overview:
- Host-side SPI initiator for the front-panel ASIC link; runs one two-byte transaction per request: command byte, then data byte.
- The front-panel device returns its reply to the command byte while the data byte is being shifted, so one transaction yields both the write effect and the reply.
- Sits in the host PLD between the CPU register interface and the front-panel ASIC pins.

Parameters:
- CLK_DIV, 4, system clocks per SPI_CK half-period; legal values are 2 to 255.
- NAK_CODE, 8'h80, reply value that sets NAK.
- GAP_HALVES, 1, minimum SS-high time after a transaction, in half-periods.

Ports:
- SCLK  in  1  system clock; all logic is on its rising edge.
- NRST  in  1  asynchronous reset, active-high.
- START  in  1  request pulse; honoured only when BUSY=0.
- CMD  in  8  command byte, captured on an accepted START.
- WDATA  in  8  data byte, captured on an accepted START.
- BUSY  out  1  high while a transaction is in progress.
- DONE  out  1  one-cycle pulse at transaction end.
- RDATA  out  8  byte received during the data-byte phase, i.e. the reply to CMD.
- NAK  out  1  high when RDATA==NAK_CODE; valid from DONE until the next DONE.
- SPI_CK  out  1  serial clock to the device; idles low.
- MOSI  out  1  serial data to the device, LSB first.
- MISO  in  1  serial data from the device, LSB first.
- SS  out  1  slave select, active-low.

Behaviour:
- Reset values (asynchronous on NRST): SS=1, SPI_CK=0, MOSI=0, BUSY=0, DONE=0, RDATA=0, NAK=0; state=IDLE; all counters 0.
- Wire protocol:
  - SPI mode 0: SPI_CK idles low.
  - The device samples MOSI on the SPI_CK rising edge and updates MISO on the rising edge.
  - The host changes MOSI on SPI_CK falling edges, and during SETUP for bit 0.
  - The host samples MISO in the SCLK cycle in which it drives SPI_CK low.
  - Exactly 16 SPI_CK pulses per transaction, never a partial byte, because the device's bit counter is not gated by SS.
- Tick generator: a half-period counter counts 0..CLK_DIV-1; a tick is produced at CLK_DIV-1. The counter is held at 0 in IDLE.
- FSM:
  - IDLE: on START & !BUSY, latch CMD and WDATA into a 16-bit shift register {WDATA,CMD}. Next cycle: SS=0, BUSY=1, MOSI=CMD[0], go to SETUP.
  - SETUP: wait 1 tick, then go to SHIFT with bit index 0 and SPI_CK=0.
  - SHIFT: each tick toggles SPI_CK.
    - 0->1 edge: no data action.
    - 1->0 edge: sample MISO into the receive shift register (shifting right, MSB in), then drive the next bit on MOSI and increment the bit index.
    - After the 16th falling edge, go to HOLD.
  - HOLD: 1 tick, then SS=1, go to GAP.
  - GAP: GAP_HALVES ticks, then BUSY=0 and DONE=1 for one cycle. RDATA and NAK are updated in the same cycle. Return to IDLE.
- RDATA is taken only from bits 8..15. Bits 0..7, the device reply to the previous transaction, are discarded.
- Latency: DONE is asserted exactly (34+GAP_HALVES)*CLK_DIV + 1 SCLK cycles after the cycle in which START is sampled. With the defaults this is 141.
- Boundary conditions:
  - START while BUSY=1 is ignored, with no queueing.
  - START in the DONE cycle is accepted; BUSY=0 in that cycle.
  - CMD and WDATA changing after acceptance have no effect.
- NRST mid-transaction: immediate abort to reset values, no DONE pulse, RDATA and NAK cleared. The device bit alignment is then undefined; the host software must also reset the device.
- Width rules: tick counter is 8 bits, bit index is 5 bits, and there is no arithmetic wrap inside a transaction.

Decomposition:
- Package fp_spi_pkg holds:
  - command codes: NO_OPERATION 8'h00, WRITE_LED_PORT 8'h01, READ_CHIP_ID 8'h06, READ_VENDOR_ID 8'h19, READ_PORT 8'h1F;
  - reply constants: CHIP_ID 8'h71, VENDOR_ID 8'hAE, ACK 8'h01, NAK 8'h80;
  - the FSM state encoding.
- One sub-module, fp_spi_tick, holds the CLK_DIV half-period divider with enable, producing the tick pulse.

Test Plan:
- CMD=8'h06, WDATA=8'h00, with the behavioural device model -> MOSI carries LSB-first 0x06 then 0x00; RDATA=8'h71, NAK=0; DONE exactly 141 cycles after START.
- CMD=8'h01, WDATA=8'hA5 -> device model LEDPORT=8'hA5; RDATA=8'h01 (ACK); 16 SPI_CK rising edges while SS=0.
- CMD=8'h42 (illegal) -> RDATA=8'h80, NAK=1; a following CMD=8'h19 transaction gives RDATA=8'hAE, NAK=0.
- START pulsed again at cycle 50 of a transaction, with CMD=8'h1F -> ignored: only one DONE, and the MOSI stream is unchanged.
- NRST asserted during the 5th SPI_CK high phase -> same cycle: SS=1, SPI_CK=0, BUSY=0; no DONE; RDATA=0.
- CLK_DIV=2 build, CMD=8'h1F with device INPUTPORT=8'h3C -> RDATA=8'h3C; DONE 71 cycles after START.

Source files
------------

// File: rtl/fp_spi_pkg.sv
// Shared definitions for the front-panel SPI link: command codes, device
// reply constants and the host FSM state encoding.
package fp_spi_pkg;

  localparam logic [7:0] NO_OPERATION   = 8'h00;
  localparam logic [7:0] WRITE_LED_PORT = 8'h01;
  localparam logic [7:0] READ_CHIP_ID   = 8'h06;
  localparam logic [7:0] READ_VENDOR_ID = 8'h19;
  localparam logic [7:0] READ_PORT      = 8'h1F;

  localparam logic [7:0] CHIP_ID   = 8'h71;
  localparam logic [7:0] VENDOR_ID = 8'hAE;
  localparam logic [7:0] ACK       = 8'h01;
  localparam logic [7:0] NAK       = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

endpackage

// File: rtl/fp_spi_tick.sv
// Half-period divider: emits a one-cycle tick every CLK_DIV enabled cycles.
// Held at zero while disabled so the first tick lands exactly CLK_DIV cycles after enable.
module fp_spi_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic SCLK,
  input  logic NRST,
  input  logic en,
  output logic tick
);

  logic [7:0] cnt;

  assign tick = en && (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge SCLK or posedge NRST) begin
    if (NRST) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/fp_spi_host.sv
// SPI mode-0 initiator: one 16-bit frame {WDATA,CMD} per START, LSB first.
// The reply to CMD arrives during the data byte and is presented on RDATA with DONE.
module fp_spi_host #(
  parameter int         CLK_DIV    = 4,
  parameter logic [7:0] NAK_CODE   = 8'h80,
  parameter int         GAP_HALVES = 1
) (
  input  logic       SCLK,
  input  logic       NRST,
  input  logic       START,
  input  logic [7:0] CMD,
  input  logic [7:0] WDATA,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] RDATA,
  output logic       NAK,
  output logic       SPI_CK,
  output logic       MOSI,
  input  logic       MISO,
  output logic       SS
);

  import fp_spi_pkg::*;

  state_t      state;
  logic [15:0] tx_sr;
  logic [15:0] rx_sr;
  logic [4:0]  bit_idx;
  logic [7:0]  gap_cnt;
  logic        tick;

  fp_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .SCLK (SCLK),
    .NRST (NRST),
    .en   (state != ST_IDLE),
    .tick (tick)
  );

  always_ff @(posedge SCLK or posedge NRST) begin
    if (NRST) begin
      state   <= ST_IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_idx <= '0;
      gap_cnt <= '0;
      SS      <= 1'b1;
      SPI_CK  <= 1'b0;
      MOSI    <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      RDATA   <= '0;
      NAK     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (START && !BUSY) begin
            tx_sr   <= {WDATA, CMD};
            rx_sr   <= '0;
            bit_idx <= '0;
            MOSI    <= CMD[0];
            SS      <= 1'b0;
            BUSY    <= 1'b1;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tick) begin
            SPI_CK  <= 1'b0;
            bit_idx <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            SPI_CK <= ~SPI_CK;
            // Falling edge: capture the device bit, then present the next one.
            if (SPI_CK) begin
              rx_sr   <= {MISO, rx_sr[15:1]};
              tx_sr   <= {1'b0, tx_sr[15:1]};
              MOSI    <= tx_sr[1];
              bit_idx <= bit_idx + 5'd1;
              if (bit_idx == 5'd15) begin
                state <= ST_HOLD;
              end
            end
          end
        end
        ST_HOLD: begin
          if (tick) begin
            SS      <= 1'b1;
            gap_cnt <= '0;
            state   <= ST_GAP;
          end
        end
        ST_GAP: begin
          // GAP_HALVES is at least 1; the first data byte reply is discarded.
          if (tick) begin
            if (gap_cnt == 8'(GAP_HALVES - 1)) begin
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              RDATA <= rx_sr[15:8];
              NAK   <= (rx_sr[15:8] == NAK_CODE);
              state <= ST_IDLE;
            end else begin
              gap_cnt <= gap_cnt + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
